// File: rtl/sq_nbit_seq_pkg.sv
// Shared types and helpers for the sequential squarer family.
package sq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sq_state_e;

  function automatic int unsigned sq_cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sq_nbit_seq_if.sv
// Operand/result handshake bundle between producer, squarer and consumer.
interface sq_nbit_seq_if #(
  parameter int unsigned W = 8
) ();

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_data;

  // Drives operands and accepts results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The squarer itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/sq_nbit_seq_abs.sv
// Combinational W-bit two's-complement magnitude; the most negative input maps to 2^(W-1).
module sq_abs #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_mag
);

  assign o_mag = i_data[W-1] ? (~i_data + 1'b1) : i_data;

endmodule

// File: rtl/sq_nbit_seq.sv
// Sequential shift-and-add squarer: one operand per handshake, 2W-bit square after W cycles.
// Define SQ_SIGNED_EN to treat in_data as two's complement (squares its magnitude).
module sq_nbit_seq
  import sq_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input logic          clk,
  input logic          rst,
  sq_nbit_seq_if.slave bus
);

  localparam int unsigned     CntW    = sq_cnt_w(W);
  localparam logic [1:0]      ST_IDLE = IDLE;
  localparam logic [1:0]      ST_CALC = CALC;
  localparam logic [1:0]      ST_DONE = DONE;
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  logic [1:0]      r_state;
  logic [W-1:0]    r_m;
  logic [2*W-1:0]  r_b;
  logic [2*W-1:0]  r_acc;
  logic [CntW-1:0] r_cnt;

  logic [W-1:0]    w_mag;
  logic            w_in_ready;
  logic            w_out_valid;

`ifdef SQ_SIGNED_EN
  sq_abs #(
    .W (W)
  ) u_abs (
    .i_data (bus.in_data),
    .o_mag  (w_mag)
  );
`else
  assign w_mag = bus.in_data;
`endif

  // Handshake flags come from registered state only.
  assign w_in_ready  = (r_state == ST_IDLE);
  assign w_out_valid = (r_state == ST_DONE);

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_m     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid && w_in_ready) begin
            r_m     <= w_mag;
            r_b     <= {{W{1'b0}}, w_mag};
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          // a*a < 2^2W, so the accumulator never wraps.
          if (r_m[0]) r_acc <= r_acc + r_b;
          r_m   <= r_m >> 1;
          r_b   <= r_b << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CntLast) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sq_nbit_seq.sv
// Directed self-checking bench for sq_nbit_seq at W=8.
module tb_sq_nbit_seq;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  sq_nbit_seq_if #(.W(W)) bus ();

  sq_nbit_seq #(
    .W (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept op, expect result exactly W edges later, then handshake with out_ready high.
  task automatic do_op(input string tag, input logic [W-1:0] op, input logic [31:0] exp);
    bus.out_ready = 1'b1;
    bus.in_data   = op;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_busy_ready"}, {31'd0, bus.in_ready}, 32'd0);
    for (int i = 1; i < W; i++) begin
      tick();
      check({tag, "_early_valid"}, {31'd0, bus.out_valid}, 32'd0);
    end
    tick();
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_data"}, {16'd0, bus.out_data}, exp);
    check({tag, "_msb"}, {31'd0, bus.out_data[2*W-1]}, {31'd0, exp[2*W-1]});
    tick();
    check({tag, "_after_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_after_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  logic [W-1:0]  ops  [3];
  logic [31:0]   exps [3];

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", {16'd0, bus.out_data}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);

    do_op("sq13", 8'd13, 32'd169);

`ifdef SQ_SIGNED_EN
    do_op("s_neg128", 8'h80, 32'd16384);
    do_op("s_neg1", 8'hFF, 32'd1);
    do_op("s_127", 8'h7F, 32'd16129);
    do_op("s_zero", 8'd0, 32'd0);
`else
    do_op("u_zero", 8'd0, 32'd0);
    do_op("u_255", 8'd255, 32'd65025);
    do_op("u_one", 8'd1, 32'd1);
`endif

    // Back-pressure: DONE held for 5 cycles with a new operand waiting.
    bus.out_ready = 1'b0;
    bus.in_data   = 8'd100;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_data = 8'd9;
    for (int i = 0; i < W; i++) tick();
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 8'(i + 20);
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_data", {16'd0, bus.out_data}, 32'd10000);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
    end
    check("bp_valid_end", {31'd0, bus.out_valid}, 32'd1);
    check("bp_data_end", {16'd0, bus.out_data}, 32'd10000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);

    // Back-to-back stream with in_valid and out_ready tied high.
    ops[0] = 8'd3;
    ops[1] = 8'd7;
    ops[2] = 8'd250;
    exps[0] = 32'd9;
    exps[1] = 32'd49;
`ifdef SQ_SIGNED_EN
    exps[2] = 32'd36;
`else
    exps[2] = 32'd62500;
`endif
    bus.out_ready = 1'b1;
    bus.in_data   = ops[0];
    bus.in_valid  = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k < 2) bus.in_data = ops[k+1];
      else bus.in_valid = 1'b0;
      for (int c = 1; c < W; c++) begin
        check("stream_busy_valid", {31'd0, bus.out_valid}, 32'd0);
        check("stream_busy_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
      end
      tick();
      check("stream_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stream_data", {16'd0, bus.out_data}, exps[k]);
      tick();
      check("stream_hs_valid", {31'd0, bus.out_valid}, 32'd0);
      check("stream_hs_ready", {31'd0, bus.in_ready}, 32'd1);
      if (k < 2) tick();
    end

    // Reset during CALC discards the in-flight result.
    bus.in_data  = 8'd200;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_busy", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_data", {16'd0, bus.out_data}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("mid_no_result", {31'd0, bus.out_valid}, 32'd0);
    end
    do_op("after_rst5", 8'd5, 32'd25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
